// File: rtl/dm_pkg.sv
// Shared constants, FSM state encoding and the load-data extension helper
// for the DataMemo access controller.
package dm_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // DataMemo returns the addressed item right-justified; only the upper bits need filling.
    function automatic logic [31:0] ld_extend(input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic        uns);
        logic [31:0] res;
        case (size)
            SIZE_BYTE: res = uns ? {24'h0, data[7:0]}  : {{24{data[7]}},  data[7:0]};
            SIZE_HALF: res = uns ? {16'h0, data[15:0]} : {{16{data[15]}}, data[15:0]};
            SIZE_WORD: res = data;
            default:   res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Request/response handshake between the MEM stage (master) and the
// DataMemo access controller (slave).
interface dm_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dm_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module dm_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store controller between the MEM stage and DataMemo: alignment/range
// checking, single-cycle store strobe, load extension and debug counters.
//
// state | meaning
// IDLE  | ready for a request; dm_we low, other dm_* hold last values
// WRITE | one cycle with dm_we high; store commits at the closing edge
// READ  | dm_addr/dm_mode held READ_LAT cycles, dm_dout sampled on the last edge
// RESP  | response presented until the consumer takes it
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int AW       = 12,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             RST,
    dm_access_ctrl_if.slave  bus,
    output logic [AW-1:0]    dm_addr,
    output logic [31:0]      dm_din,
    output logic             dm_we,
    output logic [1:0]       dm_mode,
    input  logic [31:0]      dm_dout,
    output logic [CNT_W-1:0] cnt_load,
    output logic [CNT_W-1:0] cnt_store,
    output logic [CNT_W-1:0] cnt_fault
);

    localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_e          state_q,  state_d;
    logic [AW-1:0]   addr_q,   addr_d;
    logic [31:0]     din_q,    din_d;
    logic [1:0]      mode_q,   mode_d;
    logic            uns_q,    uns_d;
    logic            we_q,     we_d;
    logic [LW-1:0]   lat_q,    lat_d;
    logic [31:0]     rdata_q,  rdata_d;
    logic            err_q,    err_d;
    logic            ready_q,  ready_d;
    logic            inc_load, inc_store, inc_fault;
    logic            fault;

    assign fault = (bus.req_size == SIZE_ILL)
                 | ((bus.req_size == SIZE_HALF) &  bus.req_addr[0])
                 | ((bus.req_size == SIZE_WORD) & (|bus.req_addr[1:0]))
                 | (|(bus.req_addr >> AW));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        din_d     = din_q;
        mode_d    = mode_q;
        uns_d     = uns_q;
        we_d      = 1'b0;
        lat_d     = lat_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        inc_load  = 1'b0;
        inc_store = 1'b0;
        inc_fault = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    rdata_d = 32'h0;
                    if (fault) begin
                        // Faulting requests never touch DataMemo, not even its address.
                        state_d   = RESP;
                        err_d     = 1'b1;
                        inc_fault = 1'b1;
                    end else begin
                        err_d  = 1'b0;
                        addr_d = bus.req_addr[AW-1:0];
                        din_d  = bus.req_wdata;
                        mode_d = bus.req_size;
                        uns_d  = bus.req_unsigned;
                        if (bus.req_we) begin
                            state_d = WRITE;
                            we_d    = 1'b1;
                        end else begin
                            state_d = READ;
                            lat_d   = LW'(READ_LAT - 1);
                        end
                    end
                end
            end
            WRITE: begin
                inc_store = 1'b1;
                state_d   = RESP;
            end
            READ: begin
                if (lat_q == '0) begin
                    rdata_d  = ld_extend(dm_dout, mode_q, uns_q);
                    inc_load = 1'b1;
                    state_d  = RESP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            mode_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            lat_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            mode_q  <= mode_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            lat_q   <= lat_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    assign dm_addr = addr_q;
    assign dm_din  = din_q;
    assign dm_we   = we_q;
    assign dm_mode = mode_q;

    dm_sat_counter #(.CNT_W(CNT_W)) u_cnt_load (
        .clk   (clk),
        .rst_n (RST),
        .inc_i (inc_load),
        .cnt_o (cnt_load)
    );

    dm_sat_counter #(.CNT_W(CNT_W)) u_cnt_store (
        .clk   (clk),
        .rst_n (RST),
        .inc_i (inc_store),
        .cnt_o (cnt_store)
    );

    dm_sat_counter #(.CNT_W(CNT_W)) u_cnt_fault (
        .clk   (clk),
        .rst_n (RST),
        .inc_i (inc_fault),
        .cnt_o (cnt_fault)
    );

endmodule
